opb_register_bank_simulink2ppc: RTL

- Multi-channel successor to the single simulink2ppc software register.
- Captures C_NUM_REGS user-side words into an OPB-readable bank, in one clock domain (OPB_Clk); the user logic is already synchronous to OPB_Clk.
- Adds per-channel capture strobes, a global freeze for coherent multi-word reads, sticky new-data flags and overrun detection.
- Sits on the PPC OPB bus beside the other software registers and snap-block address registers.

---
 rtl/opb_register_bank_simulink2ppc.sv | 123 ++++++++++++
 1 files changed

// File: rtl/opb_register_bank_simulink2ppc.sv
// rtl/opb_register_bank_simulink2ppc.sv - OPB-readable multi-channel capture bank with freeze, new-data and overrun flags
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 4,
    parameter int          C_USER_DWIDTH = 32,
    parameter              C_FAMILY      = "virtex5"
) (
    input  logic                                 OPB_Clk,
    input  logic                                 OPB_Rst,
    input  logic [0:31]                          OPB_ABus,
    input  logic [0:3]                           OPB_BE,
    input  logic [0:31]                          OPB_DBus,
    input  logic                                 OPB_RNW,
    input  logic                                 OPB_select,
    input  logic                                 OPB_seqAddr,
    output logic [0:31]                          Sl_DBus,
    output logic                                 Sl_xferAck,
    output logic                                 Sl_errAck,
    output logic                                 Sl_retry,
    output logic                                 Sl_toutSup,
    input  logic [C_NUM_REGS*C_USER_DWIDTH-1:0]  user_data_in,
    input  logic [C_NUM_REGS-1:0]                user_valid
);

    localparam int          N        = C_NUM_REGS;
    localparam int          W        = C_USER_DWIDTH;
    localparam logic [31:0] SPAN     = C_HIGHADDR - C_BASEADDR;
    localparam logic [29:0] K_CTRL   = 30'(N);
    localparam logic [29:0] K_STATUS = 30'(N + 1);
    localparam logic [29:0] K_OVR    = 30'(N + 2);

    // IBM bit 0 is the MSB, so a plain vector assignment yields LSB-0 values.
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] offset;
    logic [29:0] k;
    logic        hit;
    logic        accept;
    logic        rd_acc;
    logic        wr_acc;

    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign be     = OPB_BE;
    assign offset = addr - C_BASEADDR;
    assign k      = offset[31:2];
    assign hit    = OPB_select & (offset <= SPAN);
    assign accept = hit & ~Sl_xferAck;
    assign rd_acc = accept & OPB_RNW;
    assign wr_acc = accept & ~OPB_RNW;

    logic [W-1:0] data_q [N];
    logic         freeze_q;
    logic [N-1:0] new_q;
    logic [N-1:0] ovr_q;
    logic [N-1:0] new_d;
    logic [N-1:0] ovr_d;
    logic [N-1:0] cap;
    logic [N-1:0] rd_clr;
    logic [N-1:0] w1c;
    logic [31:0]  rd_mux;
    logic [31:0]  rd_q;

    always_comb begin
        rd_mux = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (k == 30'(i)) rd_mux = 32'(data_q[i]);
        end
        if (k == K_CTRL)   rd_mux = {31'h0, freeze_q};
        if (k == K_STATUS) rd_mux = 32'(new_q);
        if (k == K_OVR)    rd_mux = 32'(ovr_q);
    end

    // A read clearing NEW in the capture cycle keeps that capture from counting as an overrun.
    always_comb begin
        cap    = '0;
        rd_clr = '0;
        w1c    = '0;
        new_d  = '0;
        ovr_d  = '0;
        for (int i = 0; i < N; i++) begin
            cap[i]    = user_valid[i] & ~freeze_q;
            rd_clr[i] = rd_acc & (k == 30'(i));
            w1c[i]    = wr_acc & (k == K_OVR) & wdata[i] & be[i/8];
            new_d[i]  = cap[i] | (new_q[i] & ~rd_clr[i]);
            ovr_d[i]  = (cap[i] & new_q[i] & ~rd_clr[i]) | (ovr_q[i] & ~w1c[i]);
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            Sl_xferAck <= 1'b0;
            rd_q       <= 32'h0;
            freeze_q   <= 1'b0;
            new_q      <= '0;
            ovr_q      <= '0;
            for (int i = 0; i < N; i++) data_q[i] <= '0;
        end else begin
            Sl_xferAck <= accept;
            rd_q       <= rd_acc ? rd_mux : 32'h0;
            if (wr_acc && (k == K_CTRL) && be[0]) freeze_q <= wdata[0];
            new_q <= new_d;
            ovr_q <= ovr_d;
            for (int i = 0; i < N; i++) begin
                if (cap[i]) data_q[i] <= user_data_in[i*W +: W];
            end
        end
    end

    assign Sl_DBus    = rd_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0], wdata, (C_FAMILY != ""),
                         (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32)};

endmodule
